ff_de_rr_arbiter: RTL and testbench

Round-robin write arbiter for a shared data-enabled flip-flop register (D/De/Q style). Up to N_REQ requesters each present a data word and a request. The block grants one requester at a time and drives the shared register's D and De for exactly one clock per write. It then enforces a programmable idle gap before the next write. It sits between requester logic and the shared enabled register, and is the only agent allowed to drive that register's De.

---
 rtl/ff_de_rr_arbiter_pkg.sv | 22 ++
 rtl/ff_de_rr_arbiter_rr_pick.sv | 37 +++
 rtl/ff_de_rr_arbiter.sv | 115 +++++++++++
 tb/tb_ff_de_rr_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_de_rr_arbiter_pkg.sv
// Shared definitions for the round-robin D/De write arbiter:
// FSM state encoding and a constant clog2 helper for index widths.
package ff_de_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_WAIT  = 2'b10
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ff_de_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests down by the pointer,
// take the lowest set bit, then rotate the index back up.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] winner_o,
    output logic          valid_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             enc;
    int             sum;

    // Rotate, priority-encode from bit 0 upward, rotate back modulo N.
    always_comb begin
        dbl = {req_i, req_i};
        dbl = dbl >> ptr_i;
        rot = dbl[N-1:0];
        enc = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = i;
            end
        end
        sum = enc + int'(ptr_i);
        if (sum >= N) begin
            sum = sum - N;
        end
        winner_o = PW'(sum);
        valid_o  = |req_i;
    end

endmodule

// File: rtl/ff_de_rr_arbiter.sv
// Round-robin arbiter that is the sole driver of a shared enabled register:
// one-cycle De pulse per write, then a fixed idle gap before the next one.
module ff_de_rr_arbiter
    import ff_de_rr_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 1,
    parameter int GAP    = 2
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [N_REQ-1:0]          Req,
    input  logic [N_REQ*DATA_W-1:0]   D_in,
    output logic [DATA_W-1:0]         D_out,
    output logic                      De_out,
    output logic [N_REQ-1:0]          Gnt,
    output logic [N_REQ-1:0]          Ack,
    output logic                      Busy,
    output logic [clog2(N_REQ)-1:0]   Last_id
);

    localparam int PW = clog2(N_REQ);

    state_e             state_q;
    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      ptr_d;
    logic [3:0]         cnt_q;
    logic [DATA_W-1:0]  dout_q;
    logic               de_q;
    logic [N_REQ-1:0]   gnt_q;
    logic               busy_q;
    logic [PW-1:0]      last_q;

    logic [PW-1:0]      win;
    logic               win_vld;

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .req_i    (Req),
        .ptr_i    (ptr_q),
        .winner_o (win),
        .valid_o  (win_vld)
    );

    // Pointer moves to the slot just after the winner, wrapping at N_REQ.
    always_comb begin
        ptr_d = win + 1'b1;
        if (win == PW'(N_REQ - 1)) begin
            ptr_d = '0;
        end
    end

    // FSM, gap counter and all registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            de_q    <= 1'b0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            last_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_vld) begin
                        dout_q  <= D_in[win*DATA_W +: DATA_W];
                        de_q    <= 1'b1;
                        gnt_q   <= N_REQ'(1) << win;
                        last_q  <= win;
                        ptr_q   <= ptr_d;
                        busy_q  <= 1'b1;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    de_q  <= 1'b0;
                    gnt_q <= '0;
                    if (GAP == 0) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q   <= 4'(GAP - 1);
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    de_q    <= 1'b0;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign D_out   = dout_q;
    assign De_out  = de_q;
    assign Gnt     = gnt_q;
    assign Ack     = gnt_q;
    assign Busy    = busy_q;
    assign Last_id = last_q;

endmodule

// File: tb/tb_ff_de_rr_arbiter.sv
// Scoreboard bench for ff_de_rr_arbiter: GAP=2 instance for arbitration,
// GAP=0 instance for back-to-back writes.
module tb_ff_de_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] req2 = '0;
    logic [3:0] din2 = '0;
    logic       dout2;
    logic       de2;
    logic [3:0] gnt2;
    logic [3:0] ack2;
    logic       busy2;
    logic [1:0] last2;

    logic [3:0] req0 = '0;
    logic [3:0] din0 = '0;
    logic       dout0;
    logic       de0;
    logic [3:0] gnt0;
    logic [3:0] ack0;
    logic       busy0;
    logic [1:0] last0;

    typedef struct packed {
        logic [3:0] gnt;
        logic       d;
        logic [1:0] id;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_cyc = -1;
    bit sp_en = 1'b0;
    logic prev_de = 1'b0;
    logic prev_de0 = 1'b0;
    logic [3:0] pend = '0;
    logic [3:0] rearm_en = '0;

    int de_tab [4] = '{1, 0, 1, 0};
    int g_tab  [4] = '{1, 0, 8, 0};

    always #5 clk = ~clk;

    ff_de_rr_arbiter #(.N_REQ(4), .DATA_W(1), .GAP(2)) u_gap2 (
        .Clk     (clk),
        .Reset   (rst),
        .Req     (req2),
        .D_in    (din2),
        .D_out   (dout2),
        .De_out  (de2),
        .Gnt     (gnt2),
        .Ack     (ack2),
        .Busy    (busy2),
        .Last_id (last2)
    );

    ff_de_rr_arbiter #(.N_REQ(4), .DATA_W(1), .GAP(0)) u_gap0 (
        .Clk     (clk),
        .Reset   (rst),
        .Req     (req0),
        .D_in    (din0),
        .D_out   (dout0),
        .De_out  (de0),
        .Gnt     (gnt0),
        .Ack     (ack0),
        .Busy    (busy0),
        .Last_id (last0)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic d,
                        input logic [1:0] id);
        exp_t e;
        e.gnt = g;
        e.d   = d;
        e.id  = id;
        exp_q.push_back(e);
    endtask

    // Requesters drop Req on Ack and optionally re-raise it a cycle later.
    task automatic step();
        @(posedge clk);
        #1;
        req2 = (req2 | pend) & ~ack2;
        pend = ack2 & rearm_en;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy2 && n < 20) begin
            step();
            n++;
        end
        chk("idle_to", busy2, 0);
    endtask

    // Scoreboard: every De pulse of the GAP=2 instance pops one entry.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst && de2) begin
            chk("de_b2b", prev_de, 0);
            if (exp_q.size() == 0) begin
                chk("sb_unexp", de2, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_gnt", gnt2, e.gnt);
                chk("sb_ack", ack2, e.gnt);
                chk("sb_dout", dout2, e.d);
                chk("sb_last", last2, e.id);
            end
            if (sp_en) begin
                if (last_cyc >= 0) chk("de_space", cyc - last_cyc, 4);
                last_cyc = cyc;
            end
        end
        prev_de = de2;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_de", de2, 0);
        chk("rst_gnt", gnt2, 0);
        chk("rst_ack", ack2, 0);
        chk("rst_busy", busy2, 0);
        chk("rst_last", last2, 0);
        chk("rst_dout", dout2, 0);
        chk("rst_de0", de0, 0);
        chk("rst_busy0", busy0, 0);
        @(negedge clk);
        rst = 1'b0;

        // single request, then Req[1] raised in the first WAIT cycle
        @(negedge clk);
        din2 = 4'b0100;
        req2 = 4'b0100;
        push(4'b0100, 1'b1, 2'd2);
        step();
        chk("single_busy0", busy2, 1);
        chk("single_de0", de2, 1);
        step();
        chk("single_de1", de2, 0);
        chk("single_gnt1", gnt2, 0);
        chk("single_busy1", busy2, 1);
        req2[1] = 1'b1;
        push(4'b0010, 1'b0, 2'd1);
        step();
        chk("wait_gnt2", gnt2, 0);
        chk("wait_busy2", busy2, 1);
        step();
        chk("wait_gnt3", gnt2, 0);
        chk("wait_busy3", busy2, 0);
        step();
        chk("wait_gnt4", gnt2, 4'b0010);
        chk("wait_de4", de2, 1);
        wait_idle();

        // pointer wrap: grant 2, then 0011 -> 0 then 1
        din2 = 4'b0011;
        req2 = 4'b0100;
        push(4'b0100, 1'b0, 2'd2);
        step();
        wait_idle();
        req2 = 4'b0011;
        push(4'b0001, 1'b1, 2'd0);
        push(4'b0010, 1'b1, 2'd1);
        repeat (10) step();
        chk("wrap_busy", busy2, 0);

        // reset while De is high
        din2 = 4'b1000;
        req2 = 4'b1000;
        push(4'b1000, 1'b1, 2'd3);
        step();
        chk("mid_de_pre", de2, 1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_de", de2, 0);
        chk("mid_gnt", gnt2, 0);
        chk("mid_ack", ack2, 0);
        chk("mid_busy", busy2, 0);

        // rotation with all requesters active
        req2 = 4'b1111;
        din2 = 4'b0101;
        rearm_en = 4'b1111;
        pend = '0;
        sp_en = 1'b1;
        last_cyc = -1;
        push(4'b0001, 1'b1, 2'd0);
        push(4'b0010, 1'b0, 2'd1);
        push(4'b0100, 1'b1, 2'd2);
        push(4'b1000, 1'b0, 2'd3);
        push(4'b0001, 1'b1, 2'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (17) step();
        rearm_en = '0;
        pend = '0;
        req2 = '0;
        @(negedge clk);
        #1;
        sp_en = 1'b0;
        repeat (4) step();
        wait_idle();

        // GAP=0 back-to-back
        @(negedge clk);
        din0 = 4'b1000;
        req0 = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("g0_de", de0, de_tab[i]);
            chk("g0_gnt", gnt0, g_tab[i]);
            chk("g0_b2b", de0 & prev_de0, 0);
            if (i == 0) chk("g0_dout0", dout0, 0);
            if (i == 2) begin
                chk("g0_dout2", dout0, 1);
                chk("g0_last2", last0, 3);
            end
            prev_de0 = de0;
        end
        req0 = '0;
        repeat (3) @(posedge clk);

        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
